// File: rtl/dc_if.sv
// Execute-to-DC and DC-to-MEM bus bundle, with the SRAM read-data return and the bypass tap.
// The master side drives the stage inputs and the slave modport is the DC stage itself.
interface dc_if #(
  parameter int EX_TO_DC_WD  = 76,
  parameter int DC_TO_MEM_WD = 70
);
  logic [EX_TO_DC_WD-1:0]  ex_to_dc_bus;
  logic [31:0]             data_sram_rdata;
  logic [DC_TO_MEM_WD-1:0] dc_to_mem_bus;
  logic                    dc_fwd_we;
  logic [4:0]              dc_fwd_waddr;
  logic [31:0]             dc_fwd_wdata;

  modport master (
    output ex_to_dc_bus,
    output data_sram_rdata,
    input  dc_to_mem_bus,
    input  dc_fwd_we,
    input  dc_fwd_waddr,
    input  dc_fwd_wdata
  );

  modport slave (
    input  ex_to_dc_bus,
    input  data_sram_rdata,
    output dc_to_mem_bus,
    output dc_fwd_we,
    output dc_fwd_waddr,
    output dc_fwd_wdata
  );
endinterface

// File: rtl/dc.sv
// Data-cache-access pipeline stage: registers the EX bus, captures SRAM read data in the
// first DC cycle, holds it across stalls and selects load data or the ALU result.
module dc #(
  parameter int EX_TO_DC_WD  = 76,
  parameter int DC_TO_MEM_WD = 70
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [5:0] stall,
  dc_if.slave        bus
);
  localparam logic STOP = 1'b1;

  logic [EX_TO_DC_WD-1:0] ex_r;
  logic                   first_cycle;
  logic [31:0]            rdata_hold;

  logic [31:0] pc;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        bubble;
  logic        unused_mem_ctl;

  assign bubble = (stall[4] == STOP) && (stall[5] != STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r        <= '0;
      first_cycle <= 1'b0;
      rdata_hold  <= '0;
    end else begin
      if (flush || bubble) begin
        ex_r        <= '0;
        first_cycle <= 1'b0;
      end else if (stall[4] != STOP) begin
        ex_r        <= bus.ex_to_dc_bus;
        first_cycle <= 1'b1;
      end else begin
        first_cycle <= 1'b0;
      end
      // SRAM data is only valid in the first DC cycle; keep it for any later stalled cycles
      if (first_cycle)
        rdata_hold <= bus.data_sram_rdata;
    end
  end

  assign pc         = ex_r[75:44];
  assign sel_rf_res = ex_r[38];
  assign rf_we      = ex_r[37];
  assign rf_waddr   = ex_r[36:32];
  assign alu_result = ex_r[31:0];

  // RAM enable/write-enable already acted on in EX; nothing left to do with them here
  assign unused_mem_ctl = ^ex_r[43:39];

  assign load_data = first_cycle ? bus.data_sram_rdata : rdata_hold;
  assign rf_wdata  = sel_rf_res ? load_data : alu_result;

  assign bus.dc_to_mem_bus = {pc, rf_we, rf_waddr, rf_wdata};
  assign bus.dc_fwd_we     = rf_we;
  assign bus.dc_fwd_waddr  = rf_waddr;
  assign bus.dc_fwd_wdata  = rf_wdata;
endmodule

// File: tb/tb_dc.sv
// Directed bench for the DC stage: each cycle's expected outputs go into a scoreboard
// queue, and a negedge monitor pops and compares them against the bus and forwarding tap.
module tb_dc;
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [5:0] stall;

  int checks = 0;
  int errors = 0;

  logic [69:0] exp_q[$];
  string       name_q[$];

  dc_if #(.EX_TO_DC_WD(76), .DC_TO_MEM_WD(70)) bus ();

  dc #(.EX_TO_DC_WD(76), .DC_TO_MEM_WD(70)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .stall (stall),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [75:0] mk_ex(input logic [31:0] pc, input logic en,
                                        input logic [3:0] wen, input logic sel,
                                        input logic we, input logic [4:0] wa,
                                        input logic [31:0] alu);
    return {pc, en, wen, sel, we, wa, alu};
  endfunction

  function automatic logic [69:0] mk_out(input logic [31:0] pc, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    return {pc, we, wa, wd};
  endfunction

  // One cycle: rd is the SRAM data seen during this cycle, exp the outputs required now,
  // and r/f/s/ex the controls presented for the next clock edge.
  task automatic cyc(input logic r, input logic f, input logic [5:0] s,
                     input logic [75:0] ex, input logic [31:0] rd,
                     input logic [69:0] exp, input string nm);
    @(posedge clk);
    #1;
    bus.data_sram_rdata = rd;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    rst              = r;
    flush            = f;
    stall            = s;
    bus.ex_to_dc_bus = ex;
  endtask

  initial begin : monitor
    logic [69:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (bus.dc_to_mem_bus !== e) begin
          errors++;
          $display("FAIL %s bus: got %h want %h", n, bus.dc_to_mem_bus, e);
        end
        checks++;
        if (bus.dc_fwd_we !== e[37]) begin
          errors++;
          $display("FAIL %s fwd_we: got %b want %b", n, bus.dc_fwd_we, e[37]);
        end
        checks++;
        if (bus.dc_fwd_waddr !== e[36:32]) begin
          errors++;
          $display("FAIL %s fwd_waddr: got %0d want %0d", n, bus.dc_fwd_waddr, e[36:32]);
        end
        checks++;
        if (bus.dc_fwd_wdata !== e[31:0]) begin
          errors++;
          $display("FAIL %s fwd_wdata: got %h want %h", n, bus.dc_fwd_wdata, e[31:0]);
        end
      end
    end
  end

  initial begin : stim
    logic [75:0] alu1, ld1, alu2, ld2, st1, wa0, ld3, alu3;
    alu1 = mk_ex(32'hBFC00010, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5,  32'h00001234);
    ld1  = mk_ex(32'hBFC00014, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8,  32'h00000100);
    alu2 = mk_ex(32'hBFC00018, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3,  32'hCAFE0000);
    ld2  = mk_ex(32'hBFC0001C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9,  32'h00000200);
    st1  = mk_ex(32'hBFC00020, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0,  32'h00001000);
    wa0  = mk_ex(32'hBFC00024, 1'b0, 4'h0, 1'b0, 1'b1, 5'd0,  32'h00000077);
    ld3  = mk_ex(32'hBFC00028, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h00000300);
    alu3 = mk_ex(32'hBFC0002C, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4,  32'h00000005);

    rst = 1'b1; flush = 1'b0; stall = 6'b0;
    bus.ex_to_dc_bus = '0; bus.data_sram_rdata = '0;

    cyc(0, 0, 6'b000000, alu1, 32'h0,        '0, "reset");
    cyc(0, 0, 6'b000000, ld1,  32'h0,        mk_out(32'hBFC00010, 1, 5, 32'h00001234), "alu");
    cyc(0, 0, 6'b110000, alu2, 32'hDEADBEEF, mk_out(32'hBFC00014, 1, 8, 32'hDEADBEEF), "load_first");
    cyc(0, 0, 6'b110000, alu2, 32'h0,        mk_out(32'hBFC00014, 1, 8, 32'hDEADBEEF), "stall1");
    cyc(0, 0, 6'b110000, alu2, 32'h0,        mk_out(32'hBFC00014, 1, 8, 32'hDEADBEEF), "stall2");
    cyc(0, 0, 6'b010000, alu2, 32'h0,        mk_out(32'hBFC00014, 1, 8, 32'hDEADBEEF), "stall3");
    cyc(0, 0, 6'b000000, alu2, 32'h0,        '0, "bubble");
    cyc(0, 0, 6'b000000, ld2,  32'h0,        mk_out(32'hBFC00018, 1, 3, 32'hCAFE0000), "after_bubble");
    cyc(0, 0, 6'b110000, st1,  32'h11223344, mk_out(32'hBFC0001C, 1, 9, 32'h11223344), "load2_first");
    cyc(0, 1, 6'b111111, st1,  32'hFFFFFFFF, mk_out(32'hBFC0001C, 1, 9, 32'h11223344), "load2_hold");
    cyc(0, 0, 6'b000000, st1,  32'hFFFFFFFF, '0, "flush_stall");
    cyc(0, 0, 6'b000000, wa0,  32'hAAAA5555, mk_out(32'hBFC00020, 0, 0, 32'h00001000), "store");
    cyc(0, 0, 6'b000000, ld3,  32'h0,        mk_out(32'hBFC00024, 1, 0, 32'h00000077), "waddr0");
    cyc(0, 0, 6'b110000, ld3,  32'h55AA55AA, mk_out(32'hBFC00028, 1, 10, 32'h55AA55AA), "load3_first");
    cyc(1, 0, 6'b110000, alu3, 32'h0,        mk_out(32'hBFC00028, 1, 10, 32'h55AA55AA), "load3_hold");
    cyc(0, 0, 6'b000000, alu3, 32'h12345678, '0, "rst_mid");
    cyc(0, 0, 6'b000000, '0,   32'h0,        mk_out(32'hBFC0002C, 1, 4, 32'h00000005), "post_rst");
    cyc(0, 0, 6'b000000, '0,   32'h0,        '0, "idle");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dc.md
Name: dc

Overview:
- Data-cache-access pipeline stage, directly downstream of the execute stage.
- Registers the execute-to-DC bus and captures the synchronous data-SRAM read data that returns in the instruction's first DC cycle.
- Holds that read data stable across stalls and selects the load result or the ALU result.
- Drives the DC-to-MEM bus plus a forwarding tap for the bypass network.

Parameters:
- EX_TO_DC_WD, 76, input bus width (`EX_TO_DC_WD`).
- DC_TO_MEM_WD, 70, output bus width (`DC_TO_MEM_WD`).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  clear stage register to bubble
- stall  in  6 (`StallBus`)  pipeline stall vector; bit4 = this stage's input register, bit5 = downstream
- ex_to_dc_bus  in  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], alu_result[31:0]}
- data_sram_rdata  in  32  SRAM read data; valid exactly one cycle after EX issued the access
- dc_to_mem_bus  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
- dc_fwd_we  out  1  forwarding write enable (= registered rf_we)
- dc_fwd_waddr  out  5  forwarding register address
- dc_fwd_wdata  out  32  forwarding data (= rf_wdata)

Behaviour:
- Stage register, priority order:
  - rst: all fields zero.
  - flush: all fields zero.
  - stall[4]=Stop and stall[5]=NoStop: insert bubble (all fields zero).
  - stall[4]=NoStop: load ex_to_dc_bus.
  - Otherwise: hold.
- first_cycle flag:
  - Set to 1 in the cycle after a load from ex_to_dc_bus.
  - Cleared to 0 by rst, flush, bubble, or any hold cycle.
- rdata_hold register (32b):
  - When first_cycle=1, captures data_sram_rdata at the clock edge.
  - Otherwise retains its value.
  - rst clears it to 0.
- load_data = first_cycle ? data_sram_rdata : rdata_hold. Combinational, so zero added latency for an unstalled load.
- rf_wdata = sel_rf_res ? load_data : alu_result.
- Store (data_ram_en=1, wen!=0): sel_rf_res=0, rf_we=0; result passes through without side effects.
- Bubble or reset state: dc_to_mem_bus=0, dc_fwd_we=0, dc_fwd_waddr=0, dc_fwd_wdata=0.
- Reset values: every output 0; first_cycle=0.
- Forwarding outputs are combinational from the stage register and load_data; always consistent with dc_to_mem_bus.
- Multi-cycle stall with a load in DC: the captured data must stay constant even if data_sram_rdata changes from cycle 2 onward.
- Simultaneous flush and stall: flush wins.
- rst mid-stall: clears everything, including rdata_hold.
- rf_waddr=0 with rf_we=1: passed through unchanged; register-file write suppression happens downstream.
- Latency: one register stage (EX output → DC output in 1 cycle). No internal backpressure generation.

Test Plan:
- ALU op: ex bus pc=0xBFC00010, rf_we=1, waddr=5, alu_result=0x1234, sel_rf_res=0 → next cycle dc_to_mem_bus = {0xBFC00010, 1, 5, 0x00001234}; fwd_we=1, fwd_waddr=5.
- Unstalled load: sel_rf_res=1, waddr=8; rdata=0xDEADBEEF in the first DC cycle → rf_wdata=0xDEADBEEF in that same cycle.
- Load then stall[5:4]=2'b11 for 3 cycles; rdata changes to 0x0 from cycle 2 → rf_wdata stays 0xDEADBEEF for all 4 cycles.
- stall[4]=1, stall[5]=0 → next cycle all outputs 0 (bubble); following NoStop cycle loads the new instruction.
- flush=1 together with stall=6'b111111 while a load is held → next cycle all outputs 0 and first_cycle=0.
- rst asserted mid-load → next cycle all outputs 0; after rst drops, an ALU op with result 0x5 emits 0x5, not stale data.
